// File: rtl/io_poll_master.sv
// io_poll_master: CPU-side initiator for the PDU IO bus; runs the valid-flag poll handshake.
// Optional feature macro POLL_TIMEOUT_EN: abort polling after POLL_MAX failed polls (rsp_err=1).
module io_poll_master #(
  parameter logic [7:0]  ADDR_LED         = 8'h00,
  parameter logic [7:0]  ADDR_SW          = 8'h04,
  parameter logic [7:0]  ADDR_POL_OUT_VLD = 8'h08,
  parameter logic [7:0]  ADDR_POL_OUT     = 8'h0C,
  parameter logic [7:0]  ADDR_POL_IN_VLD  = 8'h10,
  parameter logic [7:0]  ADDR_POL_IN      = 8'h14,
  parameter int unsigned POLL_GAP         = 2,
  parameter int unsigned POLL_MAX         = 1000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        cmd_vld,
  output logic        cmd_rdy,
  input  logic [1:0]  cmd_op,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_vld,
  input  logic        rsp_rdy,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        busy,
  output logic [7:0]  io_addr,
  output logic [31:0] io_dout,
  output logic        io_we,
  output logic        io_rd,
  input  logic [31:0] io_din
);

  typedef enum logic [2:0] {StIdle, StPoll, StGap, StXfer, StRsp} state_e;

  // Unreachable value when POLL_GAP is 0, since GAP is then never entered.
  localparam logic [7:0] GapLast = 8'(POLL_GAP - 1);

  state_e      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] wdata_q, wdata_d;
  logic [7:0]  gap_cnt_q, gap_cnt_d;
  logic [7:0]  io_addr_q, io_addr_d;
  logic [31:0] io_dout_q, io_dout_d;
  logic        io_we_q, io_we_d;
  logic        io_rd_q, io_rd_d;
  logic        rsp_vld_q, rsp_vld_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        cmd_rdy_q, cmd_rdy_d;
  logic        busy_q, busy_d;
`ifdef POLL_TIMEOUT_EN
  localparam logic [15:0] PollMax = 16'(POLL_MAX);
  logic [15:0] poll_cnt_q, poll_cnt_d;
  logic        rsp_err_q, rsp_err_d;
`endif

  // In IDLE the command inputs are used directly so strobes launch on the accept edge.
  logic [1:0]  op_cur;
  logic [31:0] wdata_cur;
  logic [7:0]  xfer_addr, flag_addr;
  logic        flag_ready;
  logic        start_xfer, start_poll;

  assign op_cur     = (state_q == StIdle) ? cmd_op : op_q;
  assign wdata_cur  = (state_q == StIdle) ? cmd_wdata : wdata_q;
  assign xfer_addr  = op_cur[1] ? (op_cur[0] ? ADDR_POL_OUT : ADDR_POL_IN)
                                : (op_cur[0] ? ADDR_LED : ADDR_SW);
  assign flag_addr  = op_cur[0] ? ADDR_POL_OUT_VLD : ADDR_POL_IN_VLD;
  assign flag_ready = op_q[0] ? ~io_din[0] : io_din[0];

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    wdata_d    = wdata_q;
    gap_cnt_d  = gap_cnt_q;
    io_addr_d  = 8'h00;
    io_dout_d  = 32'h0;
    io_we_d    = 1'b0;
    io_rd_d    = 1'b0;
    rsp_vld_d  = rsp_vld_q;
    rsp_data_d = rsp_data_q;
    cmd_rdy_d  = cmd_rdy_q;
    busy_d     = busy_q;
    start_xfer = 1'b0;
    start_poll = 1'b0;
`ifdef POLL_TIMEOUT_EN
    poll_cnt_d = poll_cnt_q;
    rsp_err_d  = rsp_err_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (cmd_vld && cmd_rdy_q) begin
          op_d      = cmd_op;
          wdata_d   = cmd_wdata;
          cmd_rdy_d = 1'b0;
          busy_d    = 1'b1;
`ifdef POLL_TIMEOUT_EN
          poll_cnt_d = 16'h0;
`endif
          if (cmd_op[1]) begin
            state_d    = StPoll;
            start_poll = 1'b1;
          end else begin
            state_d    = StXfer;
            start_xfer = 1'b1;
          end
        end
      end
      StPoll: begin
        if (flag_ready) begin
          state_d    = StXfer;
          start_xfer = 1'b1;
        end else begin
`ifdef POLL_TIMEOUT_EN
          poll_cnt_d = poll_cnt_q + 16'd1;
          if (poll_cnt_d == PollMax) begin
            state_d    = StRsp;
            rsp_vld_d  = 1'b1;
            rsp_err_d  = 1'b1;
            rsp_data_d = 32'h0;
          end else
`endif
          if (POLL_GAP == 0) begin
            start_poll = 1'b1;
          end else begin
            state_d   = StGap;
            gap_cnt_d = 8'h00;
          end
        end
      end
      StGap: begin
        if (gap_cnt_q == GapLast) begin
          state_d    = StPoll;
          start_poll = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q + 8'd1;
        end
      end
      StXfer: begin
        state_d    = StRsp;
        rsp_vld_d  = 1'b1;
        rsp_data_d = op_q[0] ? 32'h0 : io_din;
`ifdef POLL_TIMEOUT_EN
        rsp_err_d  = 1'b0;
`endif
      end
      StRsp: begin
        if (rsp_rdy) begin
          state_d   = StIdle;
          rsp_vld_d = 1'b0;
          cmd_rdy_d = 1'b1;
          busy_d    = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    if (start_poll) begin
      io_rd_d   = 1'b1;
      io_addr_d = flag_addr;
    end
    if (start_xfer) begin
      io_addr_d = xfer_addr;
      if (op_cur[0]) begin
        io_we_d   = 1'b1;
        io_dout_d = wdata_cur;
      end else begin
        io_rd_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StIdle;
      op_q       <= 2'b00;
      wdata_q    <= 32'h0;
      gap_cnt_q  <= 8'h00;
      io_addr_q  <= 8'h00;
      io_dout_q  <= 32'h0;
      io_we_q    <= 1'b0;
      io_rd_q    <= 1'b0;
      rsp_vld_q  <= 1'b0;
      rsp_data_q <= 32'h0;
      cmd_rdy_q  <= 1'b1;
      busy_q     <= 1'b0;
`ifdef POLL_TIMEOUT_EN
      poll_cnt_q <= 16'h0;
      rsp_err_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      wdata_q    <= wdata_d;
      gap_cnt_q  <= gap_cnt_d;
      io_addr_q  <= io_addr_d;
      io_dout_q  <= io_dout_d;
      io_we_q    <= io_we_d;
      io_rd_q    <= io_rd_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_data_q <= rsp_data_d;
      cmd_rdy_q  <= cmd_rdy_d;
      busy_q     <= busy_d;
`ifdef POLL_TIMEOUT_EN
      poll_cnt_q <= poll_cnt_d;
      rsp_err_q  <= rsp_err_d;
`endif
    end
  end

  assign cmd_rdy  = cmd_rdy_q;
  assign busy     = busy_q;
  assign rsp_vld  = rsp_vld_q;
  assign rsp_data = rsp_data_q;
  assign io_addr  = io_addr_q;
  assign io_dout  = io_dout_q;
  assign io_we    = io_we_q;
  assign io_rd    = io_rd_q;
`ifdef POLL_TIMEOUT_EN
  assign rsp_err  = rsp_err_q;
`else
  assign rsp_err  = 1'b0;
`endif

endmodule

// File: tb/tb_io_poll_master.sv
// tb_io_poll_master: randomized commands against a cycle-timeline model of io_poll_master.
// Flag responder answers "not ready" for a chosen number of polls, then "ready".
module tb_io_poll_master;

  localparam int Gap     = 2;
  localparam int PollMax = 4;
  localparam logic [7:0] ALed = 8'h00, ASw = 8'h04, AOutVld = 8'h08;
  localparam logic [7:0] AOut = 8'h0C, AInVld = 8'h10, AIn = 8'h14;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cmd_vld, cmd_rdy, rsp_vld, rsp_rdy, rsp_err, busy, io_we, io_rd;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_wdata, rsp_data, io_dout, io_din;
  logic [7:0]  io_addr;

  int          n_chk = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          poll_seen = 0;
  int          poll_base = 0;
  int          poll_nr = 0;
  logic [31:0] sw_val = '0, pin_val = '0, rnd_hi = '0;
  logic        flag_rdy;

  typedef struct {
    int          cyc;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] dout;
  } ev_t;

  io_poll_master #(
    .POLL_GAP(Gap),
    .POLL_MAX(PollMax)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .cmd_vld  (cmd_vld),
    .cmd_rdy  (cmd_rdy),
    .cmd_op   (cmd_op),
    .cmd_wdata(cmd_wdata),
    .rsp_vld  (rsp_vld),
    .rsp_rdy  (rsp_rdy),
    .rsp_data (rsp_data),
    .rsp_err  (rsp_err),
    .busy     (busy),
    .io_addr  (io_addr),
    .io_dout  (io_dout),
    .io_we    (io_we),
    .io_rd    (io_rd),
    .io_din   (io_din)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    rnd_hi <= $urandom;
    if (io_rd && (io_addr == AInVld || io_addr == AOutVld)) poll_seen <= poll_seen + 1;
  end

  // Responder: flag bits carry random junk above bit 0.
  always_comb begin
    flag_rdy = (poll_seen - poll_base) >= poll_nr;
    io_din   = rnd_hi;
    case (io_addr)
      ASw:     io_din = sw_val;
      AIn:     io_din = pin_val;
      AInVld:  io_din = {rnd_hi[31:1], flag_rdy};
      AOutVld: io_din = {rnd_hi[31:1], ~flag_rdy};
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic junk_cmd();
    cmd_vld   = 1'($urandom_range(0, 1));
    cmd_op    = 2'($urandom);
    cmd_wdata = $urandom;
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [31:0] wd, input logic [31:0] sw,
                         input logic [31:0] pin, input int nr, input int stall);
    int          k, last, npoll, rsp_cyc, nmin;
    bit          tmo;
    logic [31:0] exp_data;
    ev_t         e;
    ev_t         exp_q[$];
    ev_t         got_q[$];
    sw_val    = sw;
    pin_val   = pin;
    poll_nr   = nr;
    poll_base = poll_seen;
    check("rdy_idle", 64'(cmd_rdy), 64'd1);
    cmd_vld   = 1'b1;
    cmd_op    = op;
    cmd_wdata = wd;
    rsp_rdy   = 1'b0;
    k         = cyc;

    // Expected bus timeline.
    tmo      = 1'b0;
    exp_data = op[0] ? 32'h0 : (op[1] ? pin : sw);
    if (!op[1]) begin
      e = '{k + 1, op[0], op[0] ? ALed : ASw, op[0] ? wd : 32'h0};
      exp_q.push_back(e);
      rsp_cyc = k + 2;
    end else begin
      npoll = nr + 1;
`ifdef POLL_TIMEOUT_EN
      if (nr >= PollMax) begin
        npoll    = PollMax;
        tmo      = 1'b1;
        exp_data = 32'h0;
      end
`endif
      for (int i = 0; i < npoll; i++) begin
        e = '{k + 1 + i * (1 + Gap), 1'b0, op[0] ? AOutVld : AInVld, 32'h0};
        exp_q.push_back(e);
      end
      last = k + 1 + (npoll - 1) * (1 + Gap);
      if (tmo) begin
        rsp_cyc = last + 1;
      end else begin
        e = '{last + 1, op[0], op[0] ? AOut : AIn, op[0] ? wd : 32'h0};
        exp_q.push_back(e);
        rsp_cyc = last + 2;
      end
    end

    @(negedge clk);
    check("rdy_low", 64'(cmd_rdy), 64'd0);
    check("busy_high", 64'(busy), 64'd1);
    for (int t = 0; t < 400 && !rsp_vld; t++) begin
      if (io_rd || io_we) begin
        e = '{cyc, io_we, io_addr, io_dout};
        got_q.push_back(e);
        check("rd_we_excl", 64'(io_rd & io_we), 64'd0);
      end
      if (!io_we) check("dout_zero", 64'(io_dout), 64'd0);
      junk_cmd();
      @(negedge clk);
    end

    check("rsp_vld", 64'(rsp_vld), 64'd1);
    check("rsp_cycle", 64'(cyc), 64'(rsp_cyc));
    check("n_strobes", 64'(got_q.size()), 64'(exp_q.size()));
    nmin = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < nmin; i++) begin
      check("strobe_cyc", 64'(got_q[i].cyc), 64'(exp_q[i].cyc));
      check("strobe_we", 64'(got_q[i].we), 64'(exp_q[i].we));
      check("strobe_addr", 64'(got_q[i].addr), 64'(exp_q[i].addr));
      check("strobe_dout", 64'(got_q[i].dout), 64'(exp_q[i].dout));
    end
    check("rsp_data", 64'(rsp_data), 64'(exp_data));
    check("rsp_err", 64'(rsp_err), 64'(tmo));

    for (int s = 0; s < stall; s++) begin
      check("stall_vld", 64'(rsp_vld), 64'd1);
      check("stall_data", 64'(rsp_data), 64'(exp_data));
      check("stall_rdy", 64'(cmd_rdy), 64'd0);
      check("stall_quiet", 64'(io_rd | io_we), 64'd0);
      junk_cmd();
      @(negedge clk);
    end
    rsp_rdy = 1'b1;
    @(negedge clk);
    rsp_rdy = 1'b0;
    cmd_vld = 1'b0;
    check("rsp_drop", 64'(rsp_vld), 64'd0);
    check("rdy_back", 64'(cmd_rdy), 64'd1);
    check("busy_low", 64'(busy), 64'd0);
  endtask

  // depth 1 = inside the first poll strobe, depth 2 = inside the following gap.
  task automatic reset_mid_poll(input int depth);
    poll_nr   = 1000;
    poll_base = poll_seen;
    cmd_vld   = 1'b1;
    cmd_op    = 2'b10;
    cmd_wdata = 32'h0;
    @(negedge clk);
    cmd_vld = 1'b0;
    for (int i = 1; i < depth; i++) @(negedge clk);
    check("pre_rst_rd", 64'(io_rd), 64'(depth == 1));
    check("pre_rst_busy", 64'(busy), 64'd1);
    #2 rstn = 1'b0;
    #1;
    check("rst_rd", 64'(io_rd), 64'd0);
    check("rst_we", 64'(io_we), 64'd0);
    check("rst_addr", 64'(io_addr), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_rdy", 64'(cmd_rdy), 64'd1);
    check("rst_vld", 64'(rsp_vld), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("rel_rdy", 64'(cmd_rdy), 64'd1);
    check("rel_rd", 64'(io_rd), 64'd0);
  endtask

  initial begin
    rstn      = 1'b0;
    cmd_vld   = 1'b0;
    cmd_op    = 2'b00;
    cmd_wdata = 32'h0;
    rsp_rdy   = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_rdy", 64'(cmd_rdy), 64'd1);
    check("reset_vld", 64'(rsp_vld), 64'd0);
    check("reset_data", 64'(rsp_data), 64'd0);
    check("reset_err", 64'(rsp_err), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_bus", 64'({io_addr, io_dout, io_we, io_rd}), 64'd0);
    rstn = 1'b1;
    @(negedge clk);

    run_cmd(2'b00, 32'h0, 32'h0000_A5A5, 32'h0, 0, 0);
    run_cmd(2'b01, 32'h1234_5678, 32'h0, 32'h0, 0, 1);
    run_cmd(2'b10, 32'h0, 32'h0, 32'hDEAD_BEEF, 3, 0);
    run_cmd(2'b11, 32'hCAFE_0001, 32'h0, 32'h0, 2, 2);
    run_cmd(2'b10, 32'h0, 32'h0, $urandom, 6, 0);
    reset_mid_poll(2);
    reset_mid_poll(1);
    run_cmd(2'b00, 32'h0, $urandom, 32'h0, 0, 5);
    repeat (40) begin
      run_cmd(2'($urandom), $urandom, $urandom, $urandom, $urandom_range(0, 6),
              $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
